// File: rtl/timer_cmp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_cmp_ctrl_if
// Brief    : Register-bus bundle for the timer/compare controller.
// Revision : 1.0
// ============================================================================
interface timer_cmp_ctrl_if;
    logic        cen;
    logic        wr;
    logic [2:0]  addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        error;
    logic        irq;

    modport master (
        output cen, wr, addr, wdata,
        input  rdata, error, irq
    );

    modport slave (
        input  cen, wr, addr, wdata,
        output rdata, error, irq
    );
endinterface
`default_nettype wire

// File: rtl/timer_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timer_cmp_ctrl
// Brief    : 64-bit prescaled timer with one-shot/periodic compare interrupt.
// Revision : 1.0
// ============================================================================
module timer_cmp_ctrl #(
    parameter int PRESCALE_W = 8
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    timer_cmp_ctrl_if.slave   bus
);

    localparam logic [2:0] c_ADDR_MTIME  = 3'd0;
    localparam logic [2:0] c_ADDR_CMP    = 3'd1;
    localparam logic [2:0] c_ADDR_CTRL   = 3'd2;
    localparam logic [2:0] c_ADDR_STATUS = 3'd3;
    localparam logic [2:0] c_ADDR_PERIOD = 3'd4;
    localparam logic [2:0] c_ADDR_LIMIT  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_t;

    state_t                 state_q;
    logic [63:0]            mtime_q,    mtime_d;
    logic [63:0]            mtimecmp_q, mtimecmp_d;
    logic [63:0]            period_q,   period_d;
    logic                   en_q,       en_d;
    logic                   periodic_q, periodic_d;
    logic [PRESCALE_W-1:0]  prescale_q, prescale_d;
    logic [PRESCALE_W-1:0]  pcnt_q,     pcnt_d;
    logic                   pending_q,  pending_d;

    logic        w_err;
    logic        w_we;
    logic        w_wr_mtime, w_wr_cmp, w_wr_ctrl, w_wr_status, w_wr_period;
    logic        w_tick;
    logic        w_match;
    logic        w_reload;
    logic [63:0] w_rdata;

    // Unmapped accesses are flagged and never reach any register decode.
    assign w_err       = bus.cen && (bus.addr >= c_ADDR_LIMIT);
    assign w_we        = bus.cen && bus.wr && !w_err;
    assign w_wr_mtime  = w_we && (bus.addr == c_ADDR_MTIME);
    assign w_wr_cmp    = w_we && (bus.addr == c_ADDR_CMP);
    assign w_wr_ctrl   = w_we && (bus.addr == c_ADDR_CTRL);
    assign w_wr_status = w_we && (bus.addr == c_ADDR_STATUS);
    assign w_wr_period = w_we && (bus.addr == c_ADDR_PERIOD);

    assign w_tick   = en_q && (pcnt_q == prescale_q);
    assign w_match  = (state_q == ST_ARMED) && (mtime_q >= mtimecmp_q);
    assign w_reload = periodic_q && (period_q != 64'd0);

    always_comb begin
        mtime_d = mtime_q;
        if (w_wr_mtime)
            mtime_d = bus.wdata;
        else if (w_tick)
            mtime_d = mtime_q + 64'd1;

        pcnt_d = pcnt_q;
        if (w_wr_ctrl)
            pcnt_d = '0;
        else if (en_q)
            pcnt_d = w_tick ? '0 : pcnt_q + PRESCALE_W'(1);

        // A software compare write discards the periodic auto-advance.
        mtimecmp_d = mtimecmp_q;
        if (w_wr_cmp)
            mtimecmp_d = bus.wdata;
        else if (w_match && w_reload)
            mtimecmp_d = mtimecmp_q + period_q;

        period_d = w_wr_period ? bus.wdata : period_q;

        en_d       = en_q;
        periodic_d = periodic_q;
        prescale_d = prescale_q;
        if (w_wr_ctrl) begin
            en_d       = bus.wdata[0];
            periodic_d = bus.wdata[1];
            prescale_d = bus.wdata[PRESCALE_W+1:2];
        end

        pending_d = pending_q;
        if (w_match)
            pending_d = 1'b1;
        else if (w_wr_status && bus.wdata[0])
            pending_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
            period_q   <= 64'd0;
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            pending_q  <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            period_q   <= period_d;
            en_q       <= en_d;
            periodic_q <= periodic_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            pending_q  <= pending_d;

            case (state_q)
                ST_IDLE:  ;
                ST_ARMED: if (w_match && !w_reload) state_q <= ST_FIRED;
                ST_FIRED: if (w_wr_cmp) state_q <= ST_ARMED;
                default:  state_q <= ST_IDLE;
            endcase

            // Disabling always parks the FSM; enabling only arms it from IDLE.
            if (w_wr_ctrl) begin
                if (!bus.wdata[0])
                    state_q <= ST_IDLE;
                else if (state_q == ST_IDLE)
                    state_q <= ST_ARMED;
            end
        end
    end

    always_comb begin
        w_rdata = 64'd0;
        if (bus.cen && !bus.wr) begin
            case (bus.addr)
                c_ADDR_MTIME:  w_rdata = mtime_q;
                c_ADDR_CMP:    w_rdata = mtimecmp_q;
                c_ADDR_CTRL:   w_rdata = 64'({prescale_q, periodic_q, en_q});
                c_ADDR_STATUS: w_rdata = 64'(pending_q);
                c_ADDR_PERIOD: w_rdata = period_q;
                default:       w_rdata = 64'd0;
            endcase
        end
    end

    assign bus.rdata = w_rdata;
    assign bus.error = w_err;
    assign bus.irq   = pending_q;

endmodule
`default_nettype wire

// File: doc/timer_cmp_ctrl.md
TIMER_CMP_CTRL -- requirements
Module: timer_cmp_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 8, width of the prescale field in CTRL.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn  input  1  reset: synchronous, active-low.
REQ-004 SHALL have port cen  input  1  bus access strobe, single-cycle access.
REQ-005 SHALL have port wr  input  1  1 = write, 0 = read; qualified by cen.
REQ-006 SHALL have port addr  input  3  word index: 0 MTIME, 1 MTIMECMP, 2 CTRL, 3 STATUS, 4 PERIOD, 5-7 unmapped.
REQ-007 SHALL have port wdata  input  64  write data.
REQ-008 SHALL have port rdata  output  64  read data, combinational; 0 when not (cen && !wr) or when the address is unmapped.
REQ-009 SHALL have port error  output  1  combinational: cen && (addr >= 5).
REQ-010 SHALL have port irq  output  1  registered timer interrupt, equal to STATUS.pending.

Function
REQ-011 SHALL hold MTIME (64b), MTIMECMP (64b), PERIOD (64b), CTRL {en bit0, periodic bit1, prescale bits[PRESCALE_W+1:2]}, and STATUS {pending bit0}; CTRL and STATUS read back zero-extended.
REQ-012 SHALL keep a prescale counter pcnt; while en=1, tick=1 in the cycle pcnt==prescale, then pcnt wraps to 0, otherwise pcnt increments; prescale=0 gives tick every cycle.
REQ-013 SHALL increment MTIME by 1 on tick, modulo 2^64 (all-ones wraps to 0).
REQ-014 SHALL freeze MTIME and pcnt while en=0; writing CTRL clears pcnt.
REQ-015 SHALL give a bus write to MTIME priority over a same-cycle tick increment.
REQ-016 SHALL implement FSM states IDLE, ARMED, FIRED.
REQ-017 IDLE: en=0; SHALL go to ARMED in the cycle after CTRL is written with en=1.
REQ-018 ARMED: SHALL evaluate the match condition as unsigned MTIME >= MTIMECMP every cycle, using the register values at the start of the cycle.
REQ-019 On a match with periodic=1 and PERIOD!=0, SHALL set pending and update MTIMECMP <= MTIMECMP + PERIOD (mod 2^64), and SHALL remain ARMED.
REQ-020 On a match with periodic=0 or PERIOD==0, SHALL set pending and go to FIRED.
REQ-021 FIRED: SHALL NOT set pending again; a write to MTIMECMP SHALL return the FSM to ARMED.
REQ-022 From any state, a CTRL write with en=0 SHALL go to IDLE; pending SHALL be retained.
REQ-023 A bus write to MTIMECMP in the same cycle as a periodic match SHALL win, and the auto-increment SHALL be discarded.
REQ-024 irq SHALL assert in the cycle after the match cycle (latency 1 from the match condition).
REQ-025 STATUS SHALL be write-1-to-clear on bit0; a same-cycle hardware set SHALL win over the clear.
REQ-026 A write to MTIMECMP SHALL NOT clear pending.
REQ-027 An access with error=1 SHALL change no state.
REQ-028 Reads SHALL have no side effects.

Reset
REQ-029 While rstn=0 at the clock edge: MTIME=0, MTIMECMP=all-ones, PERIOD=0, CTRL=0, pending=0, pcnt=0, FSM=IDLE; irq=0 from the next cycle.
REQ-030 Reset SHALL override any same-cycle bus write.
REQ-031 Reset asserted mid-count or while pending SHALL apply REQ-029 values.

Verification
REQ-032 One-shot match: CMP=10, CTRL=en,prescale 0 -> irq rises the cycle after MTIME reaches 10; it stays high; no re-fire after W1C while MTIME>10 (FSM stays FIRED).
REQ-033 Periodic match: CMP=5, PERIOD=4, periodic=1, en=1 -> pending set at MTIME 5, 9, 13; MTIMECMP reads 17 after the third match.
REQ-034 Prescale: prescale=3 -> MTIME increments once every 4 cycles; en=0 freezes MTIME.
REQ-035 Wrap: MTIME=all-ones with CMP=0 -> match already holds (all-ones >= 0) and pending sets before the wrap; after the tick, MTIME reads 0.
REQ-036 Collisions: W1C STATUS in the match cycle -> pending stays 1; a CMP write in a periodic match cycle -> CMP equals the written value.
REQ-037 Bus errors and reset: read addr 6 -> error=1, rdata=0, no state change; rstn=0 mid-operation -> all REQ-029 values, irq=0.
